// File: rtl/ts_os_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ts_os_gen: TS1/TS2 ordered-set burst generator feeding the PHY TX path.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ts_os_gen #(
  parameter int TS_LEN = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             ts_type,
  input  logic [CNT_W-1:0] num_sets,
  input  logic [7:0]       nfts,
  input  logic [7:0]       dri,
  input  logic [7:0]       tc,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [7:0]       txdata,
  output logic             txdatak,
  output logic             en_n,
  output logic [CNT_W-1:0] sets_sent
);

  localparam int IDX_W = $clog2(TS_LEN);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(TS_LEN - 1);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [7:0]       c_com      = 8'hBC;
  localparam logic [7:0]       c_pad      = 8'hF7;
  localparam logic [7:0]       c_ts1_id   = 8'h4A;
  localparam logic [7:0]       c_ts2_id   = 8'h45;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_set;
  logic [CNT_W-1:0] r_num;
  logic             r_type;
  logic [7:0]       r_nfts;
  logic [7:0]       r_dri;
  logic [7:0]       r_tc;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_txdata;
  logic             r_txdatak;
  logic             r_en_n;
  logic [CNT_W-1:0] r_sets_sent;

  logic [IDX_W-1:0] w_next_idx;
  logic [7:0]       w_sym_data;
  logic             w_sym_k;
  logic             w_last_set;

  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_last_set = (r_set == (r_num - c_one));

  // Symbol for the index about to be driven, so every output stays registered.
  always_comb begin
    w_sym_data = r_type ? c_ts2_id : c_ts1_id;
    w_sym_k    = 1'b0;
    if (w_next_idx == '0) begin
      w_sym_data = c_com;
      w_sym_k    = 1'b1;
    end else if (w_next_idx <= IDX_W'(2)) begin
      w_sym_data = c_pad;
      w_sym_k    = 1'b1;
    end else if (w_next_idx == IDX_W'(3)) begin
      w_sym_data = r_nfts;
    end else if (w_next_idx == IDX_W'(4)) begin
      w_sym_data = r_dri;
    end else if (w_next_idx == IDX_W'(5)) begin
      w_sym_data = r_tc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_set       <= '0;
      r_num       <= '0;
      r_type      <= 1'b0;
      r_nfts      <= '0;
      r_dri       <= '0;
      r_tc        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_txdata    <= '0;
      r_txdatak   <= 1'b0;
      r_en_n      <= 1'b1;
      r_sets_sent <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req && !abort) begin
            r_sets_sent <= '0;
            if (num_sets == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state   <= S_SEND;
              r_num     <= num_sets;
              r_type    <= ts_type;
              r_nfts    <= nfts;
              r_dri     <= dri;
              r_tc      <= tc;
              r_idx     <= '0;
              r_set     <= '0;
              r_busy    <= 1'b1;
              r_en_n    <= 1'b0;
              r_txdata  <= c_com;
              r_txdatak <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_en_n    <= 1'b1;
            r_txdata  <= '0;
            r_txdatak <= 1'b0;
          end else if (r_idx == c_last_idx) begin
            // Both the next set and the closing tail start with COM.
            if (w_last_set) r_state <= S_TAIL;
            else            r_set   <= r_set + c_one;
            r_idx     <= '0;
            r_txdata  <= c_com;
            r_txdatak <= 1'b1;
          end else begin
            r_idx     <= w_next_idx;
            r_txdata  <= w_sym_data;
            r_txdatak <= w_sym_k;
            if (w_next_idx == c_last_idx) r_sets_sent <= r_sets_sent + c_one;
          end
        end
        S_TAIL: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_en_n    <= 1'b1;
          r_txdata  <= '0;
          r_txdatak <= 1'b0;
          r_done    <= !abort;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_en_n    <= 1'b1;
          r_txdata  <= '0;
          r_txdatak <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign txdata    = r_txdata;
  assign txdatak   = r_txdatak;
  assign en_n      = r_en_n;
  assign sets_sent = r_sets_sent;

endmodule
`default_nettype wire

// File: tb/tb_ts_os_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ts_os_gen: directed and random bursts against a timeline model.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ts_os_gen;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req = 1'b0;
  logic             ts_type = 1'b0;
  logic [CNT_W-1:0] num_sets = '0;
  logic [7:0]       nfts = '0;
  logic [7:0]       dri = '0;
  logic [7:0]       tc = '0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic [7:0]       txdata;
  logic             txdatak;
  logic             en_n;
  logic [CNT_W-1:0] sets_sent;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = 0;

  ts_os_gen #(.TS_LEN(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ts_type(ts_type),
    .num_sets(num_sets), .nfts(nfts), .dri(dri), .tc(tc), .abort(abort),
    .busy(busy), .done(done), .txdata(txdata), .txdatak(txdatak),
    .en_n(en_n), .sets_sent(sets_sent)
  );

  always #5 clk = ~clk;

  // Model: a burst is a timeline t = 0 .. 16n (symbols then closing COM).
  bit       m_active = 0;
  bit       m_done   = 0;
  int       m_t      = 0;
  int       m_n      = 0;
  int       m_sets   = 0;
  bit       m_type;
  bit [7:0] m_nfts, m_dri, m_tc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_done = 0; m_t = 0; m_n = 0; m_sets = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        if (abort) m_active = 0;
        else begin
          m_t++;
          if (m_t == 16 * m_n + 1) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else if (req && !abort) begin
        m_sets = 0;
        if (num_sets == 0) m_done = 1;
        else begin
          m_active = 1; m_t = 0; m_n = int'(num_sets);
          m_type = ts_type; m_nfts = nfts; m_dri = dri; m_tc = tc;
        end
      end
      if (m_active)
        m_sets = (m_t < 16 * m_n) ? (m_t / 16 + ((m_t % 16 == 15) ? 1 : 0)) : m_n;
    end
  end

  function automatic logic [8:0] exp_sym(int idx);
    if (idx == 0) return {1'b1, 8'hBC};
    if (idx < 3)  return {1'b1, 8'hF7};
    if (idx == 3) return {1'b0, m_nfts};
    if (idx == 4) return {1'b0, m_dri};
    if (idx == 5) return {1'b0, m_tc};
    return {1'b0, (m_type ? 8'h45 : 8'h4A)};
  endfunction

  always @(negedge clk) begin
    logic [8:0]  s;
    logic [27:0] e, a;
    s = 9'h000;
    if (m_active) s = (m_t < 16 * m_n) ? exp_sym(m_t % 16) : {1'b1, 8'hBC};
    e = {s[7:0], s[8], ~m_active, m_active, m_done, CNT_W'(m_sets)};
    a = {txdata, txdatak, en_n, busy, done, sets_sent};
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle t=%0t {data,k,en_n,busy,done,sets} act=%h exp=%h", $time, a, e);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Drive req at a negedge; returns in the middle of cycle N+1.
  task automatic start(bit ty, int n, bit [7:0] f, bit [7:0] d, bit [7:0] t);
    @(negedge clk);
    req = 1; ts_type = ty; num_sets = CNT_W'(n); nfts = f; dri = d; tc = t;
    @(negedge clk);
    req = 0; ts_type = ~ty; num_sets = 16'd9; nfts = 8'hEE; dri = 8'hEE; tc = 8'hEE;
    cur = 1;
  endtask

  task automatic goto(int c);
    repeat (c - cur) @(negedge clk);
    cur = c;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_txdata", 32'(txdata), 32'h00);
    chk("reset_en_n", 32'(en_n), 32'h1);
    reset_n = 1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // Single TS1
    start(0, 1, 8'h20, 8'h02, 8'h00);
    chk("t1_com", 32'({txdata, txdatak, en_n}), 32'({8'hBC, 1'b1, 1'b0}));
    goto(4);  chk("t1_nfts", 32'(txdata), 32'h20);
    goto(5);  chk("t1_dri", 32'(txdata), 32'h02);
    goto(16); chk("t1_id", 32'({txdata, txdatak}), 32'({8'h4A, 1'b0}));
    chk("t1_sets", 32'(sets_sent), 32'h1);
    goto(17); chk("t1_close", 32'({txdata, txdatak, en_n}), 32'({8'hBC, 1'b1, 1'b0}));
    goto(18); chk("t1_done", 32'({done, en_n, busy}), 32'b110);
    goto(19); chk("t1_done_pulse", 32'(done), 32'h0);

    // Three TS2
    start(1, 3, 8'h11, 8'h04, 8'h01);
    goto(33); chk("t2_com3", 32'(txdata), 32'hBC);
    goto(48); chk("t2_id", 32'(txdata), 32'h45);
    goto(49); chk("t2_close", 32'(txdata), 32'hBC);
    goto(50); chk("t2_done", 32'({done, sets_sent}), 32'({1'b1, 16'd3}));

    // Abort mid-burst
    start(0, 4, 8'h05, 8'h02, 8'h00);
    goto(24); abort = 1;
    goto(25); abort = 0;
    chk("ab_idle", 32'({txdata, en_n, busy, sets_sent}), 32'({8'h00, 1'b1, 1'b0, 16'd1}));
    goto(66); chk("ab_no_done", 32'({done, busy}), 32'h0);

    // Zero-length burst
    start(0, 0, 8'h20, 8'h02, 8'h00);
    chk("z_done", 32'({done, en_n, sets_sent}), 32'({1'b1, 1'b1, 16'd0}));

    // Abort wins over req in IDLE
    @(negedge clk); req = 1; abort = 1; num_sets = 16'd2;
    @(negedge clk); req = 0; abort = 0;
    chk("ab_req", 32'({busy, done, en_n}), 32'b001);

    // Busy collision
    start(0, 2, 8'h01, 8'h02, 8'h03);
    goto(5); req = 1; ts_type = 1; num_sets = 16'd7;
    goto(6); req = 0;
    goto(23); chk("bc_id", 32'(txdata), 32'h4A);
    goto(34); chk("bc_done", 32'({done, sets_sent}), 32'({1'b1, 16'd2}));

    // Reset mid-set
    start(0, 3, 8'h20, 8'h02, 8'h00);
    goto(10);
    #2 reset_n = 0;
    #1 chk("rst_async", 32'({txdata, txdatak, en_n, busy, sets_sent}),
           32'({8'h00, 1'b0, 1'b1, 1'b0, 16'd0}));
    @(negedge clk); reset_n = 1;
    start(1, 1, 8'h20, 8'h02, 8'h00);
    chk("rst_restart", 32'({txdata, txdatak, busy}), 32'({8'hBC, 1'b1, 1'b1}));
    goto(20);

    // Maximum burst length must not terminate early
    start(0, 65535, 8'h33, 8'h02, 8'h00);
    goto(40); chk("max_busy", 32'(busy), 32'h1);
    abort = 1; goto(41); abort = 0;

    // Random traffic
    repeat (4000) begin
      @(negedge clk);
      req      = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 63) == 0);
      ts_type  = 1'($urandom);
      num_sets = CNT_W'($urandom_range(0, 4));
      nfts     = 8'($urandom);
      dri      = 8'($urandom);
      tc       = 8'($urandom);
    end
    @(negedge clk); req = 0; abort = 0;
    repeat (80) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ts_os_gen.md
Name: ts_os_gen

Overview:
MAC-side TS1/TS2 ordered-set generator sitting directly upstream of the PHY TX receiver.
- Emits complete 16-symbol training sets, one symbol per clock, on txdata/txdatak.
- Drives en_n so the downstream receiver only counts while a burst is active.
- The LTSSM controller requests a burst of N sets of one type and receives a done pulse when the burst completes.

Parameters:
TS_LEN, 16, symbols per ordered set (index 0..TS_LEN-1)
CNT_W, 16, width of num_sets and sets_sent

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
req  in  1  start-burst request, sampled in IDLE only
ts_type  in  1  0 = TS1, 1 = TS2
num_sets  in  CNT_W  number of sets in the burst
nfts  in  8  N_FTS field, symbol 3
dri  in  8  data rate identifier, symbol 4
tc  in  8  training control, symbol 5
abort  in  1  terminate burst immediately
busy  out  1  high in SEND and TAIL
done  out  1  one-cycle completion pulse
txdata  out  8  symbol to PHY
txdatak  out  1  K-symbol flag
en_n  out  1  low while symbols are being driven
sets_sent  out  CNT_W  completed sets in current or last burst

Behaviour:
- All outputs are registered.
- Reset and IDLE values: txdata=8'h00, txdatak=0, en_n=1, busy=0, done=0. sets_sent resets to 0 and otherwise holds its value in IDLE.
- Asserting reset_n low at any time forces IDLE and the reset values immediately. A truncated set is not completed.
- FSM states: IDLE, SEND, TAIL.
  - IDLE to SEND: req=1, abort=0, num_sets!=0. At that edge nfts, dri, tc, ts_type and num_sets are latched and sets_sent is cleared to 0. Input changes after this edge are ignored.
  - IDLE with req=1 and num_sets=0: no symbols are driven and en_n stays 1. done pulses in the following cycle and sets_sent is cleared.
  - SEND: symbol index idx runs 0..TS_LEN-1 and the set counter runs 0..num_sets-1. Sets are back to back: idx 0 of the next set follows idx 15 directly.
- Symbol map per set:
  - idx0: 8'hBC (COM), k=1
  - idx1, idx2: 8'hF7 (PAD), k=1
  - idx3: nfts, k=0
  - idx4: dri, k=0
  - idx5: tc, k=0
  - idx6..15: 8'h4A for TS1 or 8'h45 for TS2, k=0
- sets_sent increments in the cycle each idx15 is driven.
- After idx15 of the last set, go to TAIL. TAIL drives one closing COM (8'hBC, k=1, en_n=0) so the downstream counter registers the final set.
- TAIL to IDLE: in the next cycle done=1 for exactly one cycle, en_n=1, busy=0, and txdata/txdatak return to idle values.
- Latency: with req sampled at edge N, set k symbol j is on txdata during cycle N+1+16k+j. The closing COM is at N+1+16*num_sets and done is at N+2+16*num_sets.
- req while busy is ignored; the burst is not restarted.
- abort=1 in SEND or TAIL: next edge goes to IDLE with idle outputs. No closing COM, no done pulse. sets_sent holds the count of fully emitted sets.
- abort and req both high in IDLE: abort wins, no burst starts, no done.
- num_sets=2^CNT_W-1 is legal; the set counter must not wrap before the last set.

Test Plan:
1. Single TS1: req with ts_type=0, num_sets=1, nfts=8'h20, dri=8'h02, tc=8'h00.
   -> Cycles N+1..N+16 carry BC,F7,F7,20,02,00,4A×10 with k=1,1,1,0×13.
   -> N+17 carries BC, k=1. done at N+18. sets_sent=1. en_n low for N+1..N+17.
2. Three TS2 back to back: num_sets=3, ts_type=1.
   -> COM at N+1, N+17, N+33, closing COM at N+49. Identifier symbols are 8'h45. done at N+50. sets_sent=3.
   -> Downstream receiver ts2ctr=3.
3. Abort mid-burst: num_sets=4, abort pulsed during set 1 idx 7 (cycle N+24).
   -> From N+25: idle outputs, en_n=1, no closing COM, no done, sets_sent=1.
4. Zero-length burst: req with num_sets=0.
   -> No symbols, en_n stays 1, done at N+1, sets_sent=0.
5. Busy collision: second req with different ts_type at N+5 of a 2-set TS1 burst.
   -> Ignored. Stream remains TS1 and done at N+34.
6. Reset mid-set: reset_n low during set 0 idx 9.
   -> txdata=00, txdatak=0, en_n=1, busy=0, sets_sent=0 asynchronously.
   -> A new req after release starts cleanly with COM one cycle later.
